// File: rtl/ippro_stream_pkg.sv
// ippro_stream_pkg: shared defaults and FSM encoding for the IPPro streaming stages
package ippro_stream_pkg;
  localparam int DATA_W_DEFAULT = 32;
  localparam int FRAME_PIXELS_DEFAULT = 65536;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STREAM = 2'd1,
    BACKPRESSURE = 2'd2
  } state_t;
endpackage

// File: rtl/put_skid_fifo.sv
// put_skid_fifo: DEPTH x W register FIFO holding core results while the output FIFO is full
// Ports: push/din write a word (ignored when full unless popping), pop advances the head,
// dout is the head word, occ the occupancy, full/empty status.
module put_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 32,
  localparam int OW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [OW-1:0] occ,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign full = occ == OW'(DEPTH);
  assign empty = occ == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      occ <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= nxt(wr);
      end
      if (do_pop) rd <= nxt(rd);
      occ <= occ + OW'(do_push) - OW'(do_pop);
    end
  end
endmodule

// File: rtl/put_module.sv
// put_module: writes IPPro core results into the output FIFO with skid buffering and frame counting
// Ports: ENABLE/FULL gate writes, CORE_VALID/CORE_DATA carry core results, FIFO_WRITE_EN/FIFO_DATA
// drive the output FIFO, STALL_CORE backpressures the core, PIXEL_COUNT/FRAME_DONE track the frame,
// OVERFLOW is a sticky flag for results dropped on a full skid buffer.
module put_module import ippro_stream_pkg::*; #(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int SKID_DEPTH = 2,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              CORE_VALID,
  input  logic [DATA_W-1:0] CORE_DATA,
  input  logic              FULL,
  output logic              FIFO_WRITE_EN,
  output logic [DATA_W-1:0] FIFO_DATA,
  output logic              STALL_CORE,
  output logic              FRAME_DONE,
  output logic [CNT_W-1:0]  PIXEL_COUNT,
  output logic              OVERFLOW
);
  localparam int OW = $clog2(SKID_DEPTH + 1);
  logic can_write, pop, bypass, push, drop, write, last, buf_full, buf_empty;
  logic [OW-1:0] occ, occ_next;
  logic [DATA_W-1:0] head;
  state_t state, state_next;
  assign can_write = ENABLE & ~FULL;
  assign pop = can_write & ~buf_empty;
  assign bypass = can_write & buf_empty & CORE_VALID;
  assign push = CORE_VALID & ~bypass;
  assign drop = push & buf_full & ~pop;
  assign write = pop | bypass;
  assign occ_next = occ + OW'(push & ~drop) - OW'(pop);
  assign last = PIXEL_COUNT == CNT_W'(FRAME_PIXELS - 1);
  assign state_next = ~ENABLE ? IDLE : (state == IDLE) ? STREAM : FULL ? BACKPRESSURE : STREAM;
  put_skid_fifo #(.DEPTH(SKID_DEPTH), .W(DATA_W)) u_skid (
    .clk(CLK), .rst(RESET), .push(push), .pop(pop), .din(CORE_DATA),
    .dout(head), .occ(occ), .full(buf_full), .empty(buf_empty)
  );
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      FIFO_WRITE_EN <= 1'b0;
      FIFO_DATA <= '0;
      STALL_CORE <= 1'b0;
      FRAME_DONE <= 1'b0;
      PIXEL_COUNT <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      state <= state_next;
      STALL_CORE <= (state_next == IDLE) | FULL | (occ_next >= OW'(SKID_DEPTH - 1));
      FIFO_WRITE_EN <= write;
      FRAME_DONE <= write & last;
      OVERFLOW <= OVERFLOW | drop;
      if (write) begin
        FIFO_DATA <= pop ? head : CORE_DATA;
        PIXEL_COUNT <= last ? '0 : PIXEL_COUNT + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_put_module.sv
// tb_put_module: directed table-driven bench for put_module (default frame and a 4-pixel frame)
module tb_put_module;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, v = 1'b0, f = 1'b0;
  logic [31:0] d = '0;
  logic we, st, fd, ov, we4, st4, fd4, ov4;
  logic [31:0] wd, wd4;
  logic [15:0] pc, pc4;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    logic rst, en, v;
    logic [31:0] d;
    logic f, we;
    logic [31:0] wd;
    logic st;
    logic [15:0] pc;
    logic ov;
    logic [15:0] pc4;
    logic fd4;
  } vec_t;
  vec_t q[$];
  always #5 clk = ~clk;
  put_module dut (
    .CLK(clk), .RESET(rst), .ENABLE(en), .CORE_VALID(v), .CORE_DATA(d), .FULL(f),
    .FIFO_WRITE_EN(we), .FIFO_DATA(wd), .STALL_CORE(st), .FRAME_DONE(fd),
    .PIXEL_COUNT(pc), .OVERFLOW(ov)
  );
  put_module #(.FRAME_PIXELS(4)) dut4 (
    .CLK(clk), .RESET(rst), .ENABLE(en), .CORE_VALID(v), .CORE_DATA(d), .FULL(f),
    .FIFO_WRITE_EN(we4), .FIFO_DATA(wd4), .STALL_CORE(st4), .FRAME_DONE(fd4),
    .PIXEL_COUNT(pc4), .OVERFLOW(ov4)
  );
  function automatic void add(int r, int e, int vl, int dd, int ff, int xwe, int xwd,
                              int xst, int xpc, int xov, int xpc4, int xfd4);
    vec_t t;
    t.rst = 1'(r); t.en = 1'(e); t.v = 1'(vl); t.d = 32'(dd); t.f = 1'(ff);
    t.we = 1'(xwe); t.wd = 32'(xwd); t.st = 1'(xst); t.pc = 16'(xpc); t.ov = 1'(xov);
    t.pc4 = 16'(xpc4); t.fd4 = 1'(xfd4);
    q.push_back(t);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic e, input logic vl, input logic [31:0] dd, input logic ff);
    rst = r; en = e; v = vl; d = dd; f = ff;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int pulses;
    // rst en v data full | we wdata stall pc ovf | pc4 fd4
    add(1, 0, 0, 'h00, 0,  0, 'h00, 0, 0, 0,  0, 0);
    // plain streaming, bypass latency 1
    add(0, 1, 1, 'h11, 0,  1, 'h11, 0, 1, 0,  1, 0);
    add(0, 1, 1, 'h22, 0,  1, 'h22, 0, 2, 0,  2, 0);
    add(0, 1, 1, 'h33, 0,  1, 'h33, 0, 3, 0,  3, 0);
    add(0, 1, 1, 'h44, 0,  1, 'h44, 0, 4, 0,  0, 1);
    add(0, 1, 0, 'h00, 0,  0, 'h00, 0, 4, 0,  0, 0);
    // FULL for 5 cycles with a compliant core
    add(0, 1, 1, 'hA0, 0,  1, 'hA0, 0, 5, 0,  1, 0);
    add(0, 1, 1, 'hA1, 0,  1, 'hA1, 0, 6, 0,  2, 0);
    add(0, 1, 1, 'hA2, 1,  0, 'h00, 1, 6, 0,  2, 0);
    add(0, 1, 0, 'h00, 1,  0, 'h00, 1, 6, 0,  2, 0);
    add(0, 1, 0, 'h00, 1,  0, 'h00, 1, 6, 0,  2, 0);
    add(0, 1, 0, 'h00, 1,  0, 'h00, 1, 6, 0,  2, 0);
    add(0, 1, 0, 'h00, 1,  0, 'h00, 1, 6, 0,  2, 0);
    add(0, 1, 0, 'h00, 0,  1, 'hA2, 0, 7, 0,  3, 0);
    add(0, 1, 1, 'hA3, 0,  1, 'hA3, 0, 8, 0,  0, 1);
    add(0, 1, 0, 'h00, 0,  0, 'h00, 0, 8, 0,  0, 0);
    // core ignores stall: two buffered, two dropped
    add(0, 1, 1, 'hB0, 1,  0, 'h00, 1, 8, 0,  0, 0);
    add(0, 1, 1, 'hB1, 1,  0, 'h00, 1, 8, 0,  0, 0);
    add(0, 1, 1, 'hB2, 1,  0, 'h00, 1, 8, 1,  0, 0);
    add(0, 1, 1, 'hB3, 1,  0, 'h00, 1, 8, 1,  0, 0);
    add(0, 1, 0, 'h00, 0,  1, 'hB0, 1, 9, 1,  1, 0);
    add(0, 1, 0, 'h00, 0,  1, 'hB1, 0, 10, 1, 2, 0);
    add(0, 1, 0, 'h00, 0,  0, 'h00, 0, 10, 1, 2, 0);
    // reset discards buffered words
    add(0, 1, 1, 'hC0, 1,  0, 'h00, 1, 10, 1, 2, 0);
    add(0, 1, 1, 'hC1, 1,  0, 'h00, 1, 10, 1, 2, 0);
    add(1, 1, 0, 'h00, 0,  0, 'h00, 0, 0, 0,  0, 0);
    add(0, 1, 0, 'h00, 0,  0, 'h00, 0, 0, 0,  0, 0);
    add(0, 1, 0, 'h00, 0,  0, 'h00, 0, 0, 0,  0, 0);
    // disabled with one in-flight result
    add(0, 0, 1, 'h5A, 0,  0, 'h00, 1, 0, 0,  0, 0);
    add(0, 0, 0, 'h00, 0,  0, 'h00, 1, 0, 0,  0, 0);
    add(0, 1, 0, 'h00, 0,  1, 'h5A, 0, 1, 0,  1, 0);
    add(0, 1, 0, 'h00, 0,  0, 'h00, 0, 1, 0,  1, 0);
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i].rst, q[i].en, q[i].v, q[i].d, q[i].f);
      chk($sformatf("row%0d we", i), 32'(we), 32'(q[i].we));
      chk($sformatf("row%0d we4", i), 32'(we4), 32'(q[i].we));
      if (q[i].we) begin
        chk($sformatf("row%0d data", i), wd, q[i].wd);
        chk($sformatf("row%0d data4", i), wd4, q[i].wd);
      end
      chk($sformatf("row%0d stall", i), 32'(st), 32'(q[i].st));
      chk($sformatf("row%0d stall4", i), 32'(st4), 32'(q[i].st));
      chk($sformatf("row%0d count", i), 32'(pc), 32'(q[i].pc));
      chk($sformatf("row%0d overflow", i), 32'(ov), 32'(q[i].ov));
      chk($sformatf("row%0d overflow4", i), 32'(ov4), 32'(q[i].ov));
      chk($sformatf("row%0d frame_done", i), 32'(fd), 32'(0));
      chk($sformatf("row%0d count4", i), 32'(pc4), 32'(q[i].pc4));
      chk($sformatf("row%0d frame_done4", i), 32'(fd4), 32'(q[i].fd4));
    end
    // 4-pixel frame from reset: one FRAME_DONE on the 4th write
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h300 + 32'(i), 1'b0);
      pulses += int'(fd4);
      chk($sformatf("frame%0d we4", i), 32'(we4), 32'(1));
      chk($sformatf("frame%0d data4", i), wd4, 32'h300 + 32'(i));
      chk($sformatf("frame%0d count4", i), 32'(pc4), 32'((i + 1) % 4));
      chk($sformatf("frame%0d done4", i), 32'(fd4), 32'(i == 3));
      chk($sformatf("frame%0d count", i), 32'(pc), 32'(i + 1));
    end
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("frame idle done4", 32'(fd4), 32'(0));
    chk("frame pulse total", 32'(pulses), 32'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/put_module.md
Name: put_module

Overview:
- Output-side streaming stage of the IPPro datapath; mirror of the input-side FIFO-read/core-enable stage.
- Accepts results from the IPPro core, writes them into the downstream output FIFO, and applies backpressure to the core when that FIFO fills.
- Holds in-flight core results in a small skid buffer, so the core/FIFO boundary never loses data under FULL.
- Counts written pixels and flags end of frame.

Parameters:
- DATA_W, 32, width of the core result word and the FIFO data word.
- SKID_DEPTH, 2, skid-buffer entries; legal range is 2..4.
- FRAME_PIXELS, 65536, pixels per frame; must be ≥2.
- CNT_W, 16, pixel-counter width; must satisfy 2^CNT_W ≥ FRAME_PIXELS.

Ports:
- CLK  in  1  single system clock; every register is clocked on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  stage enable from the controller.
- CORE_VALID  in  1  core result valid this cycle.
- CORE_DATA  in  DATA_W  core result word.
- FULL  in  1  output FIFO cannot accept a write on the next cycle (programmable-full with ≥1 slack).
- FIFO_WRITE_EN  out  1  registered write strobe to the output FIFO.
- FIFO_DATA  out  DATA_W  registered write data.
- STALL_CORE  out  1  registered backpressure to the core; the core issues no new CORE_VALID in a cycle where this is high.
- FRAME_DONE  out  1  one-cycle pulse, registered with the last write of a frame.
- PIXEL_COUNT  out  CNT_W  number of writes so far in the current frame.
- OVERFLOW  out  1  sticky error flag: a result arrived while the skid buffer was full.

Behaviour:
- Reset (RESET=1 at a CLK edge): all outputs go to 0, the skid buffer is emptied, the counter is cleared, and state returns to IDLE. This applies mid-frame as well; buffered data is discarded.
- Definitions used below:
  - can_write = ENABLE & ~FULL.
  - occ = skid-buffer occupancy, 0..SKID_DEPTH.
- Write path, evaluated every cycle, outputs registered:
  - If can_write and occ>0: write the buffer head next cycle, then pop.
  - Else if can_write, occ==0 and CORE_VALID: write CORE_DATA next cycle. This is the bypass path, with latency 1 cycle.
  - Otherwise FIFO_WRITE_EN=0 next cycle; FIFO_DATA holds its last value.
- Buffer push: CORE_VALID is pushed when it is not taken by the bypass path, i.e. when ~can_write or occ>0.
- Simultaneous pop and push: occ is unchanged and order is preserved. Buffer order is strict FIFO; output order always equals arrival order.
- Push with occ==SKID_DEPTH and no pop in the same cycle: the word is dropped, OVERFLOW is set to 1 and held until RESET. No other state is affected.
- STALL_CORE (next) = ~ENABLE | FULL | (occ_next ≥ SKID_DEPTH-1).
  - The core may deliver at most one result after STALL_CORE rises, so SKID_DEPTH=2 guarantees no overflow with a compliant core.
- FSM, registered (reported through the stall logic only):
  - IDLE: ENABLE=0. No writes; buffer contents retained; in-flight CORE_VALID is still captured.
  - IDLE→STREAM when ENABLE=1.
  - STREAM: can_write=1.
  - STREAM→BACKPRESSURE when FULL=1.
  - BACKPRESSURE→STREAM when FULL=0 (with ENABLE=1).
  - Any state→IDLE when ENABLE=0.
  - Each buffered word drains at one word per cycle once can_write returns.
- Pixel counter:
  - Increments on every registered write.
  - On the write that makes the count reach FRAME_PIXELS: PIXEL_COUNT wraps to 0 and FRAME_DONE pulses on the same cycle as that FIFO_WRITE_EN.
  - Dropped (overflow) words are not counted.
- ENABLE deasserted mid-frame: the counter is retained and the frame resumes on re-enable.

Decomposition:
- Shared package ippro_stream_pkg holds:
  - DATA_W default;
  - FRAME_PIXELS default;
  - FSM state encoding localparams (IDLE=2'd0, STREAM=2'd1, BACKPRESSURE=2'd2).
- One sub-module is natural: put_skid_fifo, a parameterised SKID_DEPTH×DATA_W register FIFO.
  - Interface: push, pop, din, dout, occ, full, empty.
  - Synchronous reset.
  - Simultaneous push/pop is allowed when full.

Test Plan:
1. Reset, then ENABLE=1, FULL=0, CORE_VALID=1 for 4 cycles with data 0x11,0x22,0x33,0x44 → FIFO_WRITE_EN high for 4 cycles starting 1 cycle later, same data order; STALL_CORE=0; PIXEL_COUNT=4.
2. Streaming 0xA0.., then FULL=1 for 5 cycles with a compliant core → STALL_CORE rises within 1 cycle; ≤2 words buffered; on FULL=0 the buffered words are written first, in order; no gaps or duplicates; OVERFLOW=0.
3. FRAME_PIXELS=4 with 6 valid words → FRAME_DONE pulses exactly once, with the 4th write; PIXEL_COUNT sequence 1,2,3,0,1,2.
4. Hold STALL_CORE ignored: force CORE_VALID=1 for 4 cycles with FULL=1 → 2 words are buffered, the 3rd and 4th are dropped, OVERFLOW=1 and stays 1 after FULL clears; the 2 buffered words are then written.
5. Buffer holding 2 words, assert RESET for 1 cycle → next cycle FIFO_WRITE_EN=0, PIXEL_COUNT=0, OVERFLOW=0, STALL_CORE=0; buffered words are never written.
6. ENABLE=0 with 1 in-flight CORE_VALID (0x5A) → no write while disabled; STALL_CORE=1; after ENABLE=1, 0x5A is written 1 cycle later.
